fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Single-port framebuffer RAM arbiter between the VGA scanout fetch path and CPU memory-mapped loads/stores. Video fetches have absolute priority and a fixed read latency, so scanout never misses a pixel deadline. The CPU gets every cycle video does not use, through a valid/ready handshake. The block sits between the VGA timing/pixel datapath, the CPU data bus decoder and one synchronous-read block RAM.

## Interface
Parameters:
- `ADDR_W`, 16: framebuffer word address width.
- `DATA_W`, 12: pixel word width (4:4:4 RGB).

Ports:
- `clk`  in  1: system clock; one clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `vid_req`  in  1: video fetch request, one cycle per pixel word.
- `vid_addr`  in  ADDR_W: video fetch address, valid with `vid_req`.
- `vid_rvalid`  out  1: video read data valid.
- `vid_rdata`  out  DATA_W: video read data.
- `cpu_valid`  in  1: CPU request pending.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_ready`  out  1: CPU request accepted this cycle (combinational).
- `cpu_rvalid`  out  1: CPU read data valid.
- `cpu_rdata`  out  DATA_W: CPU read data.
- `mem_en`, `mem_we`  out  1: RAM enable and write enable (registered).
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W: RAM address and write data (registered).
- `mem_rdata`  in  DATA_W: RAM read data, valid the cycle after `mem_en` with `mem_we`=0.
- `stall_cnt`  out  16: saturating count of CPU stall cycles.
- `stall_clr`  in  1: synchronous clear of `stall_cnt`.

## Operation
- Grant each cycle, in priority order:
  1. `vid_req`=1 grants video.
  2. With `FB_ARB_WBUF_EN` defined only, a buffered write pending grants the drain.
  3. `cpu_valid`=1 grants the CPU.
  4. Otherwise idle (`mem_en`=0).
- `cpu_ready` = `cpu_valid` AND granted this cycle. Transfer occurs when `cpu_valid` and `cpu_ready` are both 1.
- CPU holds `cpu_we`/`cpu_addr`/`cpu_wdata` stable while `cpu_valid`=1 and `cpu_ready`=0.
- Writes produce no response. Each accepted read produces exactly one `cpu_rvalid` pulse.
- A 2-stage owner tag pipeline (`none`/`vid`/`cpu`) follows each issued read. Returning `mem_rdata` is steered to the owner's rdata register only.
- `stall_cnt` increments each cycle `cpu_valid`=1 and `cpu_ready`=0, and saturates at 0xFFFF. `stall_clr` has priority over increment.
- Reset (all outputs): every output 0, owner pipeline cleared. Reads in flight at reset never produce an rvalid.

## Timing
- Request sampled in cycle T. `mem_*` driven in T+1. `mem_rdata` arrives in T+2. `vid_rvalid`/`vid_rdata` or `cpu_rvalid`/`cpu_rdata` registered and high in T+3.
- Read latency is fixed at 3 cycles for both requesters. rvalid is a single-cycle pulse per read.
- Full-throughput video (`vid_req` every cycle): CPU fully starved, `cpu_ready`=0, `stall_cnt` counts every cycle.
- `vid_req` and `cpu_valid` in the same cycle: video issues and the CPU retries the next cycle with no lost request.
- `reset` asserted in T+1 or T+2 of a read: no rvalid for that read.

## Configuration
- `FB_ARB_WBUF_EN` defined: adds a one-entry CPU write buffer.
  - A CPU write is accepted whenever the buffer is empty, even when `vid_req`=1.
  - The buffer drains in the first cycle with `vid_req`=0. The drain appears on `mem_*` one cycle later.
  - While the buffer is full, all CPU requests (read or write) get `cpu_ready`=0, which avoids read-after-write hazards.
  - Reset empties the buffer and discards its contents.
- `FB_ARB_WBUF_EN` undefined: no buffer. CPU writes follow the same grant rule as reads.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0, `mem_en`=0, `stall_cnt`=0.
- Video read addr 0x0010, RAM returns 0xABC -> `vid_rvalid`=1 exactly 3 cycles later with `vid_rdata`=0xABC, `cpu_rvalid` stays 0.
- `vid_req` and CPU read 0x0020 in the same cycle -> video issues first, `cpu_ready`=1 one cycle later, `cpu_rvalid` 3 cycles after acceptance, `stall_cnt`=1.
- `vid_req` held 70000 cycles with `cpu_valid`=1 -> `cpu_ready` never 1, `stall_cnt` saturates at 0xFFFF. Then `stall_clr` -> 0.
- `reset` pulsed in the cycle after a CPU read is accepted -> no `cpu_rvalid` and no `vid_rvalid` afterwards.
- With `FB_ARB_WBUF_EN`: CPU write 0x0030=0x5A5 during continuous `vid_req` -> `cpu_ready`=1 immediately. A following CPU read stalls until `vid_req` drops, the write hits `mem_*` first, and the read then returns 0x5A5.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter. Video fetches win
// every cycle they ask; the CPU gets the rest via valid/ready.
// Ports: clk, reset (sync, active high); vid_req/vid_addr in,
// vid_rvalid/vid_rdata out; cpu_valid/cpu_we/cpu_addr/cpu_wdata in,
// cpu_ready (comb)/cpu_rvalid/cpu_rdata out; mem_en/mem_we/mem_addr/
// mem_wdata out (registered), mem_rdata in (one cycle after mem_en);
// stall_cnt out (saturating), stall_clr in.
// Optional macro FB_ARB_WBUF_EN adds a one-entry CPU write buffer.
module fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt,
    input  logic              stall_clr
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    logic              iss_en;
    logic              iss_we;
    logic              acc;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    owner_t            iss_own;
    owner_t            own_q1;
    owner_t            own_q2;

`ifdef FB_ARB_WBUF_EN
    logic              wbuf_full;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;
`endif

    // Grant and RAM command for this cycle; registered onto mem_* below.
    always_comb begin
        iss_en    = 1'b0;
        iss_we    = 1'b0;
        iss_addr  = vid_addr;
        iss_wdata = cpu_wdata;
        iss_own   = OWN_NONE;
        acc       = 1'b0;
        if (vid_req) begin
            iss_en  = 1'b1;
            iss_own = OWN_VID;
        end
`ifdef FB_ARB_WBUF_EN
        else if (wbuf_full) begin
            iss_en    = 1'b1;
            iss_we    = 1'b1;
            iss_addr  = wbuf_addr;
            iss_wdata = wbuf_data;
        end else if (cpu_valid && !cpu_we) begin
            iss_en   = 1'b1;
            iss_addr = cpu_addr;
            iss_own  = OWN_CPU;
            acc      = 1'b1;
        end
        // Writes land in the buffer regardless of video traffic.
        if (cpu_valid && cpu_we && !wbuf_full) begin
            acc = 1'b1;
        end
`else
        else if (cpu_valid) begin
            iss_en   = 1'b1;
            iss_we   = cpu_we;
            iss_addr = cpu_addr;
            iss_own  = cpu_we ? OWN_NONE : OWN_CPU;
            acc      = 1'b1;
        end
`endif
    end

    // Nothing is accepted during reset, so ready stays low there too.
    assign cpu_ready = acc && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            own_q1     <= OWN_NONE;
            own_q2     <= OWN_NONE;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            stall_cnt  <= '0;
        end else begin
            mem_en     <= iss_en;
            mem_we     <= iss_we;
            mem_addr   <= iss_addr;
            mem_wdata  <= iss_wdata;
            own_q1     <= iss_own;
            own_q2     <= own_q1;
            // own_q2 lines up with mem_rdata of the tagged read.
            vid_rvalid <= (own_q2 == OWN_VID);
            cpu_rvalid <= (own_q2 == OWN_CPU);
            if (own_q2 == OWN_VID) begin
                vid_rdata <= mem_rdata;
            end
            if (own_q2 == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end
            if (stall_clr) begin
                stall_cnt <= '0;
            end else if (cpu_valid && !cpu_ready
                         && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

`ifdef FB_ARB_WBUF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_full <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
        end else if (!vid_req && wbuf_full) begin
            wbuf_full <= 1'b0;
        end else if (cpu_valid && cpu_we && !wbuf_full) begin
            wbuf_full <= 1'b1;
            wbuf_addr <= cpu_addr;
            wbuf_data <= cpu_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: random + directed bench for fb_arbiter with a
// schedule-based reference model and a behavioural block RAM.
module tb_fb_arbiter;
    localparam int AW = 16;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   stall_cnt;
    logic          stall_clr = 1'b0;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        logic [15:0] t;
        if (a == 16'h0010) return 12'hABC;
        if (a == 16'h0020) return 12'h123;
        t = (a * 16'd37) ^ 16'h05A3;
        return t[DW-1:0];
    endfunction

    // Behavioural synchronous-read RAM.
    logic [DW-1:0] ram [0:65535];
    bit            ram_wr [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr]
                                              : init_word(mem_addr);
            end
        end
    end

    // Reference model: expected outputs scheduled per future cycle.
    typedef struct packed {
        logic          men;
        logic          mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        logic          vv;
        logic [DW-1:0] vd;
        logic          cv;
        logic [DW-1:0] cd;
    } slot_t;

    slot_t         sched [8];
    logic [DW-1:0] shadow [0:65535];
    bit            sh_wr [0:65535];
    int            cyc = 0;
    int            m_stall = 0;
    bit            m_buf_full = 0;
    logic [AW-1:0] m_buf_a = '0;
    logic [DW-1:0] m_buf_d = '0;
    bit            armed = 0;

    int tests = 0;
    int fails = 0;
    bit last_ready = 0;
    bit saw_crv = 0;
    bit saw_vrv = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return sh_wr[a] ? shadow[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic compare(input bit exp_ready);
        slot_t e;
        e = sched[cyc % 8];
        chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, exp_ready});
        chk("mem_en", {31'd0, mem_en}, {31'd0, e.men});
        if (e.men) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.mwe});
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.maddr});
            if (e.mwe) chk("mem_wdata", {20'd0, mem_wdata}, {20'd0, e.mwd});
        end
        chk("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, e.vv});
        if (e.vv) chk("vid_rdata", {20'd0, vid_rdata}, {20'd0, e.vd});
        chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.cv});
        if (e.cv) chk("cpu_rdata", {20'd0, cpu_rdata}, {20'd0, e.cd});
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    endtask

    // who: 0 = no response, 1 = video, 2 = cpu
    task automatic issue(input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int who);
        int n1;
        int n3;
        n1 = (cyc + 1) % 8;
        n3 = (cyc + 3) % 8;
        sched[n1].men   = 1'b1;
        sched[n1].mwe   = we;
        sched[n1].maddr = a;
        sched[n1].mwd   = d;
        if (we) begin
            shadow[a] = d;
            sh_wr[a]  = 1'b1;
        end else if (who == 1) begin
            sched[n3].vv = 1'b1;
            sched[n3].vd = mem_word(a);
        end else if (who == 2) begin
            sched[n3].cv = 1'b1;
            sched[n3].cd = mem_word(a);
        end
    endtask

    task automatic step(input bit rst, input bit vr,
                        input logic [AW-1:0] va, input bit cv,
                        input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit clr);
        bit er;
        reset     = rst;
        vid_req   = vr;
        vid_addr  = va;
        cpu_valid = cv;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        stall_clr = clr;
        #1;
        er = 1'b0;
        if (!rst && cv) begin
`ifdef FB_ARB_WBUF_EN
            er = !m_buf_full && (cw || !vr);
`else
            er = !vr;
`endif
        end
        if (armed) compare(er);
        last_ready = cpu_ready;
        if (cpu_rvalid) saw_crv = 1'b1;
        if (vid_rvalid) saw_vrv = 1'b1;
        sched[cyc % 8] = '0;
        if (rst) begin
            for (int i = 0; i < 8; i++) sched[i] = '0;
            m_buf_full = 1'b0;
            m_stall    = 0;
            armed      = 1'b1;
        end else begin
            if (vr) begin
                issue(1'b0, va, '0, 1);
            end
`ifdef FB_ARB_WBUF_EN
            else if (m_buf_full) begin
                issue(1'b1, m_buf_a, m_buf_d, 0);
                m_buf_full = 1'b0;
            end else if (cv && !cw) begin
                issue(1'b0, ca, '0, 2);
            end
            if (er && cw) begin
                m_buf_full = 1'b1;
                m_buf_a    = ca;
                m_buf_d    = cd;
            end
`else
            else if (cv) begin
                issue(cw, ca, cd, cw ? 0 : 2);
            end
`endif
            if (clr) m_stall = 0;
            else if (cv && !er && m_stall < 65535) m_stall++;
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, '0, 0);
    endtask

    bit            p_v;
    bit            p_w;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    bit            got_rdy;

    initial begin
        for (int i = 0; i < 8; i++) sched[i] = '0;

        // Reset then idle.
        step(1, 0, '0, 0, 0, '0, '0, 0);
        step(1, 0, '0, 0, 0, '0, '0, 0);
        idle(10);
        chk("idle_mem_en", {31'd0, mem_en}, 0);
        chk("idle_mem_addr", {16'd0, mem_addr}, 0);
        chk("idle_vid_rvalid", {31'd0, vid_rvalid}, 0);
        chk("idle_vid_rdata", {20'd0, vid_rdata}, 0);
        chk("idle_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("idle_cpu_rdata", {20'd0, cpu_rdata}, 0);
        chk("idle_stall", {16'd0, stall_cnt}, 0);
        chk("idle_ready", {31'd0, last_ready}, 0);

        // Video read of 0x0010.
        step(0, 1, 16'h0010, 0, 0, '0, '0, 0);
        chk("vid_mem_en", {31'd0, mem_en}, 1);
        chk("vid_mem_addr", {16'd0, mem_addr}, 32'h0010);
        idle(2);
        chk("vid_rvalid_t3", {31'd0, vid_rvalid}, 1);
        chk("vid_rdata_t3", {20'd0, vid_rdata}, 32'hABC);
        chk("vid_cpu_rvalid", {31'd0, cpu_rvalid}, 0);
        idle(1);
        chk("vid_rvalid_pulse", {31'd0, vid_rvalid}, 0);

        // Video and CPU read collide.
        step(0, 1, 16'h0050, 1, 0, 16'h0020, '0, 0);
        chk("coll_ready0", {31'd0, last_ready}, 0);
        step(0, 0, '0, 1, 0, 16'h0020, '0, 0);
        chk("coll_ready1", {31'd0, last_ready}, 1);
        chk("coll_stall", {16'd0, stall_cnt}, 1);
        chk("coll_mem_addr", {16'd0, mem_addr}, 32'h0020);
        idle(2);
        chk("coll_cpu_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("coll_cpu_rdata", {20'd0, cpu_rdata}, 32'h123);
        idle(2);

        // Reset in the cycle after a CPU read is accepted.
        step(0, 0, '0, 1, 0, 16'h0040, '0, 0);
        chk("rst_acc", {31'd0, last_ready}, 1);
        saw_crv = 0;
        saw_vrv = 0;
        step(1, 0, '0, 0, 0, '0, '0, 0);
        idle(5);
        chk("rst_no_cpu_rvalid", {31'd0, saw_crv}, 0);
        chk("rst_no_vid_rvalid", {31'd0, saw_vrv}, 0);

`ifdef FB_ARB_WBUF_EN
        // Buffered write during continuous video.
        step(0, 1, 16'h0001, 1, 1, 16'h0030, 12'h5A5, 0);
        chk("wb_acc", {31'd0, last_ready}, 1);
        got_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, AW'(i), 1, 0, 16'h0030, '0, 0);
            if (last_ready) got_rdy = 1;
        end
        chk("wb_rd_stall", {31'd0, got_rdy}, 0);
        step(0, 0, '0, 1, 0, 16'h0030, '0, 0);
        chk("wb_drain_ready", {31'd0, last_ready}, 0);
        chk("wb_drain_en", {31'd0, mem_en}, 1);
        chk("wb_drain_we", {31'd0, mem_we}, 1);
        chk("wb_drain_addr", {16'd0, mem_addr}, 32'h0030);
        chk("wb_drain_data", {20'd0, mem_wdata}, 32'h5A5);
        step(0, 0, '0, 1, 0, 16'h0030, '0, 0);
        chk("wb_rd_ready", {31'd0, last_ready}, 1);
        idle(2);
        chk("wb_rd_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("wb_rd_rdata", {20'd0, cpu_rdata}, 32'h5A5);
        idle(2);
`endif

        // Random traffic with a CPU that holds requests until ready.
        p_v = 0;
        p_w = 0;
        p_a = '0;
        p_d = '0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit vr;
            bit clr;
            int vp;
            vp  = ((i / 400) % 2 == 1) ? 85 : 30;
            r   = ($urandom_range(0, 249) == 0);
            vr  = ($urandom_range(0, 99) < vp);
            clr = ($urandom_range(0, 99) == 0);
            if (!p_v && $urandom_range(0, 99) < 60) begin
                p_v = 1;
                p_w = 1'($urandom_range(0, 1));
                p_a = 16'h0100 + AW'($urandom_range(0, 15));
                p_d = DW'($urandom);
            end
            step(r, vr, AW'($urandom), p_v, p_w, p_a, p_d, clr);
            if (last_ready) p_v = 0;
        end
        step(0, 0, '0, 0, 0, '0, '0, 1);
        idle(4);

        // Full-rate video starves the CPU; counter saturates.
        got_rdy = 0;
        for (int i = 0; i < 70000; i++) begin
            step(0, 1, AW'(i), 1, 0, 16'h0200, '0, 0);
            if (last_ready) got_rdy = 1;
        end
        chk("starve_ready", {31'd0, got_rdy}, 0);
        chk("starve_sat", {16'd0, stall_cnt}, 32'hFFFF);
        step(0, 0, '0, 0, 0, '0, '0, 1);
        chk("starve_clr", {16'd0, stall_cnt}, 0);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
